// File: rtl/switch_ms_if.sv
// Token-side bundle of the multi-stream SWITCH actor: one tagged producer in,
// PORTS write-side outputs each carrying one full flag per flux.
interface switch_ms_if #(
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

  // Producer side: in_port_write is a plain valid, with no ready; the producer
  // should honour in_port_full[tag], because a token sent to a full queue is dropped.
  // Output side: out_port_write[p] is a one-cycle strobe. It is never raised
  // for flux f on port p while out_port_full[p*FLUX+f] is high in the cycle
  // the write is granted.
  logic                     in_port_write;
  logic [WIDTH-1:0]         in_port_datain;
  logic [FLUX-1:0]          in_port_full;
  logic [PORTS-1:0]         out_port_write;
  logic [PORTS*WIDTH-1:0]   out_port_dataout;
  logic [PORTS*FLUX-1:0]    out_port_full;

  modport master (
    output in_port_write, in_port_datain, out_port_full,
    input  in_port_full, out_port_write, out_port_dataout
  );

  modport slave (
    input  in_port_write, in_port_datain, out_port_full,
    output in_port_full, out_port_write, out_port_dataout
  );
endinterface

// File: rtl/switch_ms.sv
// Multi-stream SWITCH: per-flux queues dealt round-robin across PORTS outputs.
// Define SWITCH_MS_STRICT_PRIO_EN for a fixed-priority arbiter in which the lowest flux wins.
module switch_ms #(
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  switch_ms_if.slave bus
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam int PW        = $clog2(DEPTH);
  localparam int SW        = $clog2(PORTS);

  logic [WIDTH-1:0]       r_mem [FLUX][DEPTH];
  logic [PW-1:0]          r_wr  [FLUX];
  logic [PW-1:0]          r_rd  [FLUX];
  logic [PW:0]            r_cnt [FLUX];
  logic [SW-1:0]          r_sel [FLUX];
  logic [PORTS-1:0]       r_write;
  logic [PORTS*WIDTH-1:0] r_dout;
`ifndef SWITCH_MS_STRICT_PRIO_EN
  logic [TAG_WIDTH-1:0]   r_rr;
`endif

  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_tag_ok;
  logic                   w_push_ok;
  logic [FLUX-1:0]        w_full;
  logic [FLUX-1:0]        w_push;
  logic [FLUX-1:0]        w_pop;
  logic [FLUX-1:0]        w_elig;
  logic                   w_gnt_vld;
  logic [TAG_WIDTH-1:0]   w_gnt;
  logic [SW-1:0]          w_gsel;
  logic [WIDTH-1:0]       w_head;

  assign w_tag     = bus.in_port_datain[WIDTH-1 -: TAG_WIDTH];
  assign w_tag_ok  = (32'(w_tag) < FLUX);
  // Fullness is taken before any pop in the same cycle, so a full queue rejects writes even while draining.
  assign w_push_ok = bus.in_port_write && w_tag_ok && !w_full[w_tag];

  always_comb begin
    w_full = '0;
    w_push = '0;
    w_elig = '0;
    for (int f = 0; f < FLUX; f++) begin
      w_full[f] = (r_cnt[f] == (PW+1)'(DEPTH));
      w_push[f] = w_push_ok && (32'(w_tag) == f);
      w_elig[f] = (r_cnt[f] != '0) &&
                  !bus.out_port_full[int'(r_sel[f])*FLUX + f];
    end
  end

  // Scan in reverse so that the last hit, which is the first in scan order, wins.
  always_comb begin
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    idx       = 0;
    for (int k = FLUX-1; k >= 0; k--) begin
`ifdef SWITCH_MS_STRICT_PRIO_EN
      idx = k;
`else
      idx = (int'(r_rr) + k) % FLUX;
`endif
      if (w_elig[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = TAG_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int f = 0; f < FLUX; f++) begin
      w_pop[f] = w_gnt_vld && (32'(w_gnt) == f);
    end
  end

  assign w_gsel = r_sel[w_gnt];
  assign w_head = r_mem[w_gnt][r_rd[w_gnt]];

  // Queue storage needs no reset; empty pointers/counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_tag][r_wr[w_tag]] <= bus.in_port_datain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        r_wr[f]  <= '0;
        r_rd[f]  <= '0;
        r_cnt[f] <= '0;
        r_sel[f] <= '0;
      end
      r_write <= '0;
      r_dout  <= '0;
`ifndef SWITCH_MS_STRICT_PRIO_EN
      r_rr    <= '0;
`endif
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (w_push[f]) r_wr[f] <= r_wr[f] + PW'(1);
        if (w_pop[f])  r_rd[f] <= r_rd[f] + PW'(1);
        case ({w_push[f], w_pop[f]})
          2'b10:   r_cnt[f] <= r_cnt[f] + (PW+1)'(1);
          2'b01:   r_cnt[f] <= r_cnt[f] - (PW+1)'(1);
          default: r_cnt[f] <= r_cnt[f];
        endcase
      end
      r_write <= '0;
      if (w_gnt_vld) begin
        r_write[w_gsel]                      <= 1'b1;
        r_dout[int'(w_gsel)*WIDTH +: WIDTH]  <= w_head;
        r_sel[w_gnt] <= (w_gsel == SW'(PORTS-1)) ? '0 : w_gsel + SW'(1);
`ifndef SWITCH_MS_STRICT_PRIO_EN
        r_rr <= (w_gnt == TAG_WIDTH'(FLUX-1)) ? '0 : w_gnt + TAG_WIDTH'(1);
`endif
      end
    end
  end

  assign bus.in_port_full     = w_full;
  assign bus.out_port_write   = r_write;
  assign bus.out_port_dataout = r_dout;
endmodule
